// File: rtl/branch_pkg.sv
// Shared types and constants for the branch-resolution / BHT predictor block.
package branch_pkg;

  // 2-bit saturating predictor counter; bit [1] is the prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  localparam bht_cnt_t BHT_INIT = WNT;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned CMP_W = 3;

  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // comparator flag positions
  localparam int unsigned CMP_EQ  = 0;
  localparam int unsigned CMP_LT  = 1;
  localparam int unsigned CMP_LTU = 2;

  // Conditional-branch outcome from funct3 and the comparator flags
  function automatic logic branch_cond(input logic [F3_W-1:0]  f3,
                                       input logic [CMP_W-1:0] cmp);
    logic res;
    res = 1'b0;
    case (f3)
      F3_BEQ:  res =  cmp[CMP_EQ];
      F3_BNE:  res = ~cmp[CMP_EQ];
      F3_BLT:  res =  cmp[CMP_LT];
      F3_BGE:  res = ~cmp[CMP_LT];
      F3_BLTU: res =  cmp[CMP_LTU];
      F3_BGEU: res = ~cmp[CMP_LTU];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_sat_update.sv
// Next-state of one 2-bit saturating predictor counter.
module bht_sat_update
  import branch_pkg::*;
(
  input  bht_cnt_t cur_i,
  input  logic     taken_i,
  output bht_cnt_t next_o
);

  // Step toward strong-taken or strong-not-taken, holding at the ends
  always_comb begin
    next_o = cur_i;
    case (cur_i)
      SNT:     next_o = taken_i ? WNT : SNT;
      WNT:     next_o = taken_i ? WT  : SNT;
      WT:      next_o = taken_i ? ST  : WNT;
      ST:      next_o = taken_i ? ST  : WT;
      default: next_o = BHT_INIT;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver with a direct-mapped 2-bit BHT predictor and statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             id_pred_taken,
  input  logic             branch_flag,
  input  logic [OPC_W-1:0] opcode7,
  input  logic [F3_W-1:0]  func3,
  input  logic [CMP_W-1:0] id_comparator,
  output logic             branch_taken,
  output logic             redirect,
  output logic             redirect_fallthrough,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;

  bht_cnt_t            bht_q [ENTRIES];
  logic [CNT_W-1:0]    stat_br_q, stat_br_d;
  logic [CNT_W-1:0]    stat_mp_q, stat_mp_d;

  logic [IDX_BITS-1:0] if_idx_c;
  logic [IDX_BITS-1:0] id_idx_c;
  logic                is_cond_c;
  logic                is_jal_c;
  logic                cond_taken_c;
  logic                commit_c;
  bht_cnt_t            bht_upd_c;
  logic                unused_pc_bits_c;

  assign if_idx_c = if_pc[IDX_BITS+1:2];
  assign id_idx_c = id_pc[IDX_BITS+1:2];
  assign unused_pc_bits_c = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0],
                              id_pc[XLEN-1:IDX_BITS+2], id_pc[1:0]};

  // Same-cycle prediction; a write in this cycle is not bypassed
  assign if_pred_taken = bht_q[if_idx_c][1];

  assign is_cond_c    = branch_flag & (opcode7 == OP_BRANCH);
  assign is_jal_c     = branch_flag & (opcode7 == OP_JAL);
  assign cond_taken_c = branch_cond(func3, id_comparator);
  assign commit_c     = id_valid & ~id_stall & is_cond_c;

  // Zero-latency resolution; JALR and non-branches leave everything low
  always_comb begin
    branch_taken         = 1'b0;
    redirect             = 1'b0;
    redirect_fallthrough = 1'b0;
    if (id_valid) begin
      if (is_cond_c) begin
        branch_taken         = cond_taken_c;
        redirect             = cond_taken_c ^ id_pred_taken;
        redirect_fallthrough = ~cond_taken_c;
      end else if (is_jal_c) begin
        branch_taken         = 1'b1;
        redirect             = ~id_pred_taken;
        redirect_fallthrough = 1'b0;
      end
    end
  end

  bht_sat_update u_sat (
    .cur_i   (bht_q[id_idx_c]),
    .taken_i (cond_taken_c),
    .next_o  (bht_upd_c)
  );

  // Saturating statistics next-state, advanced only on commit
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (commit_c) begin
      if (stat_br_q != '1) stat_br_d = stat_br_q + CNT_W'(1);
      if (redirect && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + CNT_W'(1);
    end
  end

  // Table and statistics registers; reset wins over a pending commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) bht_q[i] <= BHT_INIT;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
      if (commit_c) bht_q[id_idx_c] <= bht_upd_c;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: directed steps plus random traffic against a table model.
module tb_branch_predict_unit;

  localparam logic [6:0] T_OP_BR   = 7'b1100011;
  localparam logic [6:0] T_OP_JAL  = 7'b1101111;
  localparam logic [6:0] T_OP_JALR = 7'b1100111;
  localparam logic [6:0] T_OP_ALU  = 7'b0110011;

  logic        clk, rst;
  logic [31:0] if_pc, id_pc;
  logic        id_valid, id_stall, id_pred_taken, branch_flag;
  logic [6:0]  opcode7;
  logic [2:0]  func3, id_comparator;
  logic        if_pred_taken, branch_taken, redirect, redirect_fallthrough;
  logic [31:0] stat_branches, stat_mispredicts;
  logic        if_pred4, taken4, redir4, ft4;
  logic [3:0]  stat_br4, stat_mp4;

  int checks = 0;
  int errors = 0;

  // reference model state
  int     m_bht [64];
  longint m_br, m_mp;

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .branch_flag(branch_flag),
    .opcode7(opcode7), .func3(func3), .id_comparator(id_comparator),
    .branch_taken(branch_taken), .redirect(redirect),
    .redirect_fallthrough(redirect_fallthrough),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred4),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .branch_flag(branch_flag),
    .opcode7(opcode7), .func3(func3), .id_comparator(id_comparator),
    .branch_taken(taken4), .redirect(redir4),
    .redirect_fallthrough(ft4),
    .stat_branches(stat_br4), .stat_mispredicts(stat_mp4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit ref_outcome(input logic [2:0] f3, input logic [2:0] cmp);
    case (f3)
      3'd0: return cmp[0];
      3'd1: return !cmp[0];
      3'd4: return cmp[1];
      3'd5: return !cmp[1];
      3'd6: return cmp[2];
      3'd7: return !cmp[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[idx(pc)] >= 2;
  endfunction

  // One cycle: drive, check combinational outputs, clock, update model, check stats
  task automatic step(input bit r, input bit v, input bit st, input bit fl,
                      input logic [6:0] op, input logic [2:0] f3,
                      input logic [2:0] cmp, input logic [31:0] ipc,
                      input bit pred, input logic [31:0] fpc, input string tag);
    bit cond, jal, t, e_t, e_r, e_f, commit;
    rst = r; id_valid = v; id_stall = st; branch_flag = fl; opcode7 = op;
    func3 = f3; id_comparator = cmp; id_pc = ipc; id_pred_taken = pred;
    if_pc = fpc;
    #3;
    cond = fl && (op == T_OP_BR);
    jal  = fl && (op == T_OP_JAL);
    t    = ref_outcome(f3, cmp);
    e_t = 0; e_r = 0; e_f = 0;
    if (v && cond) begin e_t = t; e_r = t ^ pred; e_f = !t; end
    else if (v && jal) begin e_t = 1; e_r = !pred; e_f = 0; end
    chk({tag, ".taken"}, longint'(branch_taken), longint'(e_t));
    chk({tag, ".redirect"}, longint'(redirect), longint'(e_r));
    chk({tag, ".fallthru"}, longint'(redirect_fallthrough), longint'(e_f));
    chk({tag, ".ifpred"}, longint'(if_pred_taken), longint'(m_pred(fpc)));
    chk({tag, ".redirect4"}, longint'(redir4), longint'(e_r));
    chk({tag, ".ifpred4"}, longint'(if_pred4), longint'(m_pred(fpc)));
    commit = v && !st && cond;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_br = 0; m_mp = 0;
    end else if (commit) begin
      if (t) m_bht[idx(ipc)] = (m_bht[idx(ipc)] == 3) ? 3 : m_bht[idx(ipc)] + 1;
      else   m_bht[idx(ipc)] = (m_bht[idx(ipc)] == 0) ? 0 : m_bht[idx(ipc)] - 1;
      m_br++;
      if (e_r) m_mp++;
    end
    chk({tag, ".stat_br"}, longint'(stat_branches), sat(m_br, 64'hFFFF_FFFF));
    chk({tag, ".stat_mp"}, longint'(stat_mispredicts), sat(m_mp, 64'hFFFF_FFFF));
    chk({tag, ".stat_br4"}, longint'(stat_br4), sat(m_br, 15));
    chk({tag, ".stat_mp4"}, longint'(stat_mp4), sat(m_mp, 15));
  endtask

  task automatic idle(input logic [31:0] fpc, input string tag);
    step(0, 0, 0, 0, T_OP_ALU, 3'd0, 3'd0, 32'h0, 0, fpc, tag);
  endtask

  initial begin
    logic [6:0] ops [4];
    logic [31:0] pcs [6];
    bit p;
    ops[0] = T_OP_BR; ops[1] = T_OP_JAL; ops[2] = T_OP_JALR; ops[3] = T_OP_ALU;
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h140;
    pcs[3] = 32'h88; pcs[4] = 32'h1000; pcs[5] = 32'hFC;
    foreach (m_bht[i]) m_bht[i] = 1;
    m_br = 0; m_mp = 0;
    rst = 1; id_valid = 0; id_stall = 0; branch_flag = 0; opcode7 = T_OP_ALU;
    func3 = 0; id_comparator = 0; id_pc = 0; id_pred_taken = 0; if_pc = 0;
    @(posedge clk); #1;

    // reset, then sweep every index
    step(1, 0, 0, 0, T_OP_ALU, 0, 0, 0, 0, 0, "reset");
    for (int a = 0; a < 256; a += 4) idle(32'(a), "sweep");

    // BEQ at 0x40 taken three times, prediction taken from the table
    for (int k = 0; k < 3; k++) begin
      p = m_pred(32'h40);
      step(0, 1, 0, 1, T_OP_BR, 3'd0, 3'b001, 32'h40, p, 32'h40, "beq_train");
    end
    idle(32'h40, "beq_pred");
    idle(32'h140, "alias");

    // all funct3 codes with comparator = lt only
    for (int f = 0; f < 8; f++)
      step(0, 1, 0, 1, T_OP_BR, 3'(f), 3'b010, 32'h200 + 32'(f * 4), 0,
           32'h200 + 32'(f * 4), "funct3");

    // BNE taken held by stall for 4 cycles, then released
    for (int k = 0; k < 4; k++)
      step(0, 1, 1, 1, T_OP_BR, 3'd1, 3'b000, 32'h88, 0, 32'h88, "stall");
    step(0, 1, 0, 1, T_OP_BR, 3'd1, 3'b000, 32'h88, 0, 32'h88, "stall_rel");
    idle(32'h88, "stall_after");

    // JAL with pred 0 and 1, JALR, invalid and non-branch
    step(0, 1, 0, 1, T_OP_JAL, 3'd0, 3'd0, 32'h300, 0, 32'h300, "jal0");
    step(0, 1, 0, 1, T_OP_JAL, 3'd0, 3'd0, 32'h300, 1, 32'h300, "jal1");
    step(0, 1, 0, 1, T_OP_JALR, 3'd0, 3'b001, 32'h300, 0, 32'h300, "jalr");
    step(0, 0, 0, 1, T_OP_BR, 3'd0, 3'b001, 32'h300, 0, 32'h300, "invalid");
    step(0, 1, 0, 0, T_OP_BR, 3'd0, 3'b001, 32'h300, 0, 32'h300, "noflag");

    // 20 branches: 4-bit counter must pin at 15
    for (int k = 0; k < 20; k++)
      step(0, 1, 0, 1, T_OP_BR, 3'd0, 3'($urandom_range(0, 7)), 32'h400,
           1'($urandom_range(0, 1)), 32'h400, "sat20");
    chk("stat4_pinned", longint'(stat_br4), 15);

    // same-index write and read in one cycle: IF sees pre-update value
    step(0, 1, 0, 1, T_OP_BR, 3'd0, 3'b001, 32'h500, 0, 32'h500, "bypass_a");
    step(0, 1, 0, 1, T_OP_BR, 3'd0, 3'b001, 32'h500, 1, 32'h500, "bypass_b");

    // reset in the same cycle as a taken commit: reset wins, entry back to 01
    step(1, 1, 0, 1, T_OP_BR, 3'd0, 3'b001, 32'h80, 0, 32'h80, "rst_commit");
    idle(32'h80, "rst_after");
    step(0, 1, 0, 1, T_OP_BR, 3'd0, 3'b001, 32'h80, 0, 32'h80, "rst_retrain");
    idle(32'h80, "rst_retrain_pred");

    // random traffic
    for (int k = 0; k < 300; k++)
      step(0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) != 0), ops[$urandom_range(0, 3)],
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
           pcs[$urandom_range(0, 5)], "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch-resolution block with a dynamic predictor: a direct-mapped branch history table (BHT) of 2-bit saturating counters gives a taken/not-taken prediction in IF, and the ID-stage resolver evaluates the branch from the comparator flags. It drives a redirect request when the prediction was wrong and trains the BHT. It also keeps branch and misprediction statistics. It replaces the purely combinational ID branch decision in the 5-stage core and sits between the IF PC mux and the ID comparator.

## Interface
- XLEN, 32: PC width.
- IDX_BITS, 6: BHT index width; the table has 2**IDX_BITS entries.
- CNT_W, 32: width of the statistics counters.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  PC being fetched.
- if_pred_taken  out  1  prediction for if_pc (combinational read of the table).
- id_valid  in  1  ID holds a valid instruction.
- id_stall  in  1  ID is frozen this cycle (memory/AXI wait).
- id_pc  in  XLEN  PC of the ID instruction.
- id_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- branch_flag  in  1  decoder marks a branch/jump class instruction.
- opcode7  in  7  ID opcode.
- func3  in  3  ID funct3.
- id_comparator  in  3  [0] eq, [1] signed lt, [2] unsigned lt.
- branch_taken  out  1  resolved outcome (JAL is always 1; JALR is always 0 here).
- redirect  out  1  misprediction; IF must be flushed.
- redirect_fallthrough  out  1  with redirect: 1 = fetch id_pc+4, 0 = fetch the branch target.
- stat_branches  out  CNT_W  conditional branches resolved.
- stat_mispredicts  out  CNT_W  conditional mispredictions.

## Operation
- Index = pc[IDX_BITS+1:2]. No tags, so aliasing is allowed.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the counter's bit [1].
- A conditional branch is branch_flag & (opcode7 == OP_BRANCH).
- Outcome per funct3:
  - BEQ = eq; BNE = ~eq.
  - BLT = lt; BGE = ~lt.
  - BLTU = ltu; BGEU = ~ltu.
  - Any other funct3 gives 0.
- JAL (opcode7 == OP_JAL with branch_flag):
  - branch_taken = 1.
  - redirect = ~id_pred_taken, with redirect_fallthrough = 0.
  - No BHT update, no statistics.
- JALR: branch_taken = 0, redirect = 0. JALR is handled elsewhere.
- Conditional branch:
  - redirect = taken XOR id_pred_taken.
  - redirect_fallthrough = ~taken.
- When branch_flag = 0 or id_valid = 0: branch_taken, redirect and redirect_fallthrough are all 0.
- Resolve commit = id_valid & ~id_stall & conditional. On commit:
  - BHT[idx(id_pc)] increments when taken, decrements otherwise, saturating at 11 and 00.
  - stat_branches += 1; stat_mispredicts += redirect.
  - Both statistics counters saturate at all-ones and never wrap.
- During id_stall the outputs still reflect the current inputs, but there is no table update and no counting. A branch held for N stall cycles is therefore counted once, on the cycle id_stall drops.

## Timing
- Prediction: if_pred_taken is combinational from if_pc and the table registers, so it is valid in the same cycle.
- Resolution: branch_taken, redirect and redirect_fallthrough are combinational from the ID inputs, with zero latency.
- BHT write and statistics increment happen at the clock edge ending the commit cycle and are visible from the next cycle.
- Same-cycle read/write of the same index: IF sees the old counter value; there is no bypass.
- Reset:
  - All BHT entries go to 01 (weak-NT), so if_pred_taken = 0 for every PC.
  - Both statistics counters go to 0.
  - Reset takes effect at the first clk edge with rst = 1.
- Reset asserted mid-operation discards any pending commit in that cycle: reset has priority over update.
- Combinational outputs are not gated by rst; the pipeline's own reset invalidates id_valid.

## Structure
- Package branch_pkg holds:
  - typedef bht_cnt_t (2-bit enum SNT/WNT/WT/ST) and BHT_INIT = WNT.
  - The funct3 and opcode constants, reused from the shared defines.
- Sub-module bht_sat_update: combinational next-state for one 2-bit counter (cur, taken -> next).
- The table is a register array, not SRAM: it needs reset, and 64x2 bits is small enough to keep in flops.

## Test plan
- Reset, then sweep if_pc over 0x0–0xFC: if_pred_taken = 0 everywhere; both stats read 0.
- BEQ at id_pc 0x40, eq = 1, taken three times (pred from table):
  - Counter goes 01 -> 10 -> 11 -> 11.
  - redirect = 1 only on the first resolve.
  - stat_branches = 3, stat_mispredicts = 1.
  - if_pc 0x40 then predicts 1.
- Aliasing: train 0x40 to strong-T, then query if_pc 0x140 (IDX_BITS = 6): if_pred_taken = 1.
- All six funct3 codes with id_comparator = 3'b010: outcomes are BEQ 0, BNE 1, BLT 1, BGE 0, BLTU 0, BGEU 1.
- Stall and control-flow cases:
  - BNE taken held with id_stall = 1 for 4 cycles: redirect stays asserted throughout, but the counter and stats change exactly once, after stall release.
  - JAL with pred 0: redirect = 1, fallthrough = 0, no stat change.
  - JALR: branch_taken = 0, redirect = 0.
- Saturation, commit/reset priority and bypass:
  - Force CNT_W = 4 and resolve 20 branches: stat_branches holds at 15.
  - Assert rst in the same cycle as a commit: the entry reads 01 afterwards.
  - Same-index read/write in one cycle: IF sees the pre-update value.
